// File: rtl/mem_stage_pkg.sv
// Shared types and decode helpers for the memory stage: opcodes, access sizes,
// FSM states and load/store classification.
package mem_stage_pkg;

  typedef enum logic [4:0] {
    ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLL_I, SRL_I, SRA_I,
    SLT_I, SLTU_I, LUI_I,
    LB_I, LH_I, LW_I, LBU_I, LHU_I,
    SB_I, SH_I, SW_I
  } instr_opcode;

  typedef enum logic [1:0] {MSZ_B, MSZ_H, MSZ_W} mem_size_e;

  typedef enum logic {IDLE, REQ} mem_state_e;

  function automatic logic is_load(input instr_opcode op);
    return (op == LB_I) || (op == LH_I) || (op == LW_I) || (op == LBU_I) || (op == LHU_I);
  endfunction

  function automatic logic is_store(input instr_opcode op);
    return (op == SB_I) || (op == SH_I) || (op == SW_I);
  endfunction

  function automatic logic is_unsigned_load(input instr_opcode op);
    return (op == LBU_I) || (op == LHU_I);
  endfunction

  // Non-memory opcodes report word size; callers gate on is_load/is_store.
  function automatic mem_size_e mem_size(input instr_opcode op);
    case (op)
      LB_I, LBU_I, SB_I: return MSZ_B;
      LH_I, LHU_I, SH_I: return MSZ_H;
      default:           return MSZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] a);
    case (size)
      MSZ_H:   return a[0];
      MSZ_W:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data extraction: picks the byte/half at the access offset
// and sign- or zero-extends it to the full datapath width.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      a,
  input  mem_size_e       size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{a, 3'b000} +: 8];
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MSZ_B:   result = {{(XLEN-8){~is_unsigned & byte_sel[7]}}, byte_sel};
      MSZ_H:   result = {{(XLEN-16){~is_unsigned & half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results to writeback, or issues a single data-memory
// request for aligned loads/stores and returns the aligned result.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            agex_valid,
  output logic            agex_ready,
  input  instr_opcode     agex_opcode,
  input  logic [XLEN-1:0] agex_aluout,
  input  logic [XLEN-1:0] agex_st_data,
  input  logic [RD_W-1:0] agex_rd,
  input  logic            agex_rd_we,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_we,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_exc
);

  mem_state_e      state_q, state_d;
  instr_opcode     op_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      wstrb_q;
  logic [RD_W-1:0] rd_q;
  logic            rd_we_q;
  logic            flushed_q;

  logic            accept;
  logic            is_mem_in;
  logic            misaligned_in;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] load_data;

  assign accept        = agex_valid & agex_ready & ~flush;
  assign is_mem_in     = is_load(agex_opcode) | is_store(agex_opcode);
  assign misaligned_in = is_misaligned(mem_size(agex_opcode), agex_aluout[1:0]);

  // Store lanes are steered at accept time so the request fields are plain registers.
  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = agex_st_data;
    case (mem_size(agex_opcode))
      MSZ_B: begin
        st_wstrb = 4'b0001 << agex_aluout[1:0];
        st_wdata = {4{agex_st_data[7:0]}};
      end
      MSZ_H: begin
        st_wstrb = 4'b0011 << agex_aluout[1:0];
        st_wdata = {2{agex_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem_in && !misaligned_in) state_d = REQ;
      REQ:     if (dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    agex_ready = (state_q == IDLE);
    dmem_req   = (state_q == REQ);
  end

  assign dmem_we    = is_store(op_q);
  assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (dmem_rdata),
    .a           (addr_q[1:0]),
    .size        (mem_size(op_q)),
    .is_unsigned (is_unsigned_load(op_q)),
    .result      (load_data)
  );

  // A flush seen at any point of the request suppresses its writeback at ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_exc    <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      op_q      <= ADD_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_exc   <= 1'b0;
      if (accept) begin
        if (!is_mem_in) begin
          wb_valid <= 1'b1;
          wb_data  <= agex_aluout;
          wb_we    <= agex_rd_we;
          wb_rd    <= agex_rd;
        end else if (misaligned_in) begin
          wb_valid <= 1'b1;
          wb_exc   <= 1'b1;
          wb_data  <= agex_aluout;
          wb_rd    <= agex_rd;
        end else begin
          op_q      <= agex_opcode;
          addr_q    <= agex_aluout;
          wdata_q   <= st_wdata;
          wstrb_q   <= is_store(agex_opcode) ? st_wstrb : 4'b0000;
          rd_q      <= agex_rd;
          rd_we_q   <= agex_rd_we;
          flushed_q <= 1'b0;
        end
      end
      if (state_q == REQ) begin
        if (flush) flushed_q <= 1'b1;
        if (dmem_ack && !flush && !flushed_q) begin
          wb_valid <= 1'b1;
          wb_rd    <= rd_q;
          wb_we    <= is_load(op_q) & rd_we_q;
          wb_data  <= is_load(op_q) ? load_data : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a scoreboard queue holds expected writebacks,
// a monitor pops and checks them, and the main sequence checks memory signals.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        agex_valid;
  logic        agex_ready;
  instr_opcode agex_opcode;
  logic [31:0] agex_aluout;
  logic [31:0] agex_st_data;
  logic [4:0]  agex_rd;
  logic        agex_rd_we;
  logic        flush;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        wb_exc;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        exc;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mem_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .agex_valid   (agex_valid),
    .agex_ready   (agex_ready),
    .agex_opcode  (agex_opcode),
    .agex_aluout  (agex_aluout),
    .agex_st_data (agex_st_data),
    .agex_rd      (agex_rd),
    .agex_rd_we   (agex_rd_we),
    .flush        (flush),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_we        (wb_we),
    .wb_data      (wb_data),
    .wb_exc       (wb_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic [4:0] rd, input logic we, input logic [31:0] data,
                         input logic exc, input logic chk_data);
    exp_t e;
    e.rd = rd; e.we = we; e.data = data; e.exc = exc; e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  // Drives one instruction for a single cycle and returns at the following negedge.
  task automatic applyStimulus(input instr_opcode op, input logic [31:0] alu,
                               input logic [31:0] st, input logic [4:0] rd, input logic we);
    agex_opcode  = op;
    agex_aluout  = alu;
    agex_st_data = st;
    agex_rd      = rd;
    agex_rd_we   = we;
    agex_valid   = 1'b1;
    @(negedge clk);
    agex_valid   = 1'b0;
  endtask

  task automatic memAck(input logic [31:0] rdata);
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  // Writeback monitor: every wb_valid pulse must match the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && wb_valid) begin
      if (sb.size() == 0) begin
        checkOutput("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("wb_rd", 32'(wb_rd), 32'(e.rd));
        checkOutput("wb_we", 32'(wb_we), 32'(e.we));
        checkOutput("wb_exc", 32'(wb_exc), 32'(e.exc));
        if (e.chk_data) checkOutput("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; agex_valid = 1'b0; agex_opcode = ADD_I; agex_aluout = 32'h0;
    agex_st_data = 32'h0; agex_rd = 5'd0; agex_rd_we = 1'b0; flush = 1'b0;
    dmem_rdata = 32'h0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_wb_we", 32'(wb_we), 32'd0);
    checkOutput("rst_wb_exc", 32'(wb_exc), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_ready", 32'(agex_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] ALU pass-through");
    pushExp(5'd5, 1'b1, 32'h0000_1234, 1'b0, 1'b1);
    applyStimulus(ADD_I, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    checkOutput("alu_no_req", 32'(dmem_req), 32'd0);
    checkOutput("alu_ready", 32'(agex_ready), 32'd1);
    pushExp(5'd9, 1'b0, 32'hCAFE_0001, 1'b0, 1'b1);
    applyStimulus(XOR_I, 32'hCAFE_0001, 32'h0, 5'd9, 1'b0);
    pushExp(5'd10, 1'b1, 32'h8000_0002, 1'b0, 1'b1);
    applyStimulus(SLL_I, 32'h8000_0002, 32'h0, 5'd10, 1'b1);

    $display("[TB] flush with valid drops instruction");
    agex_opcode = LW_I; agex_aluout = 32'h400; agex_rd = 5'd3; agex_rd_we = 1'b1;
    agex_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    agex_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_drop_req", 32'(dmem_req), 32'd0);

    $display("[TB] byte/half/word loads");
    pushExp(5'd6, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1);
    applyStimulus(LB_I, 32'h0000_0103, 32'h0, 5'd6, 1'b1);
    checkOutput("lb_req", 32'(dmem_req), 32'd1);
    checkOutput("lb_addr", dmem_addr, 32'h0000_0100);
    checkOutput("lb_we", 32'(dmem_we), 32'd0);
    checkOutput("lb_ready", 32'(agex_ready), 32'd0);
    memAck(32'h8000_0000);
    checkOutput("lb_req_done", 32'(dmem_req), 32'd0);
    pushExp(5'd7, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
    applyStimulus(LBU_I, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    memAck(32'h8000_0000);
    pushExp(5'd8, 1'b1, 32'hFFFF_8000, 1'b0, 1'b1);
    applyStimulus(LH_I, 32'h0000_0102, 32'h0, 5'd8, 1'b1);
    memAck(32'h8000_1234);
    pushExp(5'd8, 1'b1, 32'h0000_8000, 1'b0, 1'b1);
    applyStimulus(LHU_I, 32'h0000_0102, 32'h0, 5'd8, 1'b1);
    memAck(32'h8000_1234);
    pushExp(5'd11, 1'b1, 32'h0000_00AB, 1'b0, 1'b1);
    applyStimulus(LBU_I, 32'h0000_0101, 32'h0, 5'd11, 1'b1);
    memAck(32'h1234_AB56);
    pushExp(5'd12, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    applyStimulus(LW_I, 32'h0000_0200, 32'h0, 5'd12, 1'b1);
    checkOutput("lw_addr", dmem_addr, 32'h0000_0200);
    memAck(32'hDEAD_BEEF);

    $display("[TB] stores");
    pushExp(5'd13, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(SH_I, 32'h0000_0102, 32'h1234_ABCD, 5'd13, 1'b1);
    checkOutput("sh_we", 32'(dmem_we), 32'd1);
    checkOutput("sh_wstrb", 32'(dmem_wstrb), 32'h0000_000C);
    checkOutput("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    checkOutput("sh_addr", dmem_addr, 32'h0000_0100);
    memAck(32'h0);
    pushExp(5'd14, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(SB_I, 32'h0000_0301, 32'h0000_0055, 5'd14, 1'b1);
    checkOutput("sb_wstrb", 32'(dmem_wstrb), 32'h0000_0002);
    checkOutput("sb_wdata", dmem_wdata, 32'h5555_5555);
    memAck(32'h0);
    pushExp(5'd15, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(SW_I, 32'h0000_0304, 32'h0BAD_F00D, 5'd15, 1'b0);
    checkOutput("sw_wstrb", 32'(dmem_wstrb), 32'h0000_000F);
    checkOutput("sw_wdata", dmem_wdata, 32'h0BAD_F00D);
    memAck(32'h0);

    $display("[TB] misaligned accesses");
    pushExp(5'd16, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(LW_I, 32'h0000_0101, 32'h0, 5'd16, 1'b1);
    checkOutput("mis_lw_req", 32'(dmem_req), 32'd0);
    pushExp(5'd17, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(SH_I, 32'h0000_0103, 32'h1111_2222, 5'd17, 1'b1);
    checkOutput("mis_sh_req", 32'(dmem_req), 32'd0);

    $display("[TB] delayed ack with held-off instruction");
    pushExp(5'd18, 1'b1, 32'h5A5A_A5A5, 1'b0, 1'b1);
    applyStimulus(LW_I, 32'h0000_0A08, 32'h0, 5'd18, 1'b1);
    pushExp(5'd19, 1'b1, 32'h0000_0077, 1'b0, 1'b1);
    agex_opcode = ADD_I; agex_aluout = 32'h77; agex_rd = 5'd19; agex_rd_we = 1'b1;
    agex_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_req", 32'(dmem_req), 32'd1);
      checkOutput("hold_addr", dmem_addr, 32'h0000_0A08);
      checkOutput("hold_ready", 32'(agex_ready), 32'd0);
      if (i < 2) @(negedge clk);
    end
    memAck(32'h5A5A_A5A5);
    checkOutput("hold_ready_after", 32'(agex_ready), 32'd1);
    @(negedge clk);
    agex_valid = 1'b0;

    $display("[TB] flush during request");
    applyStimulus(LW_I, 32'h0000_0C00, 32'h0, 5'd20, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_req_held", 32'(dmem_req), 32'd1);
    @(negedge clk);
    memAck(32'h1234_5678);
    checkOutput("flush_req_done", 32'(dmem_req), 32'd0);
    pushExp(5'd21, 1'b1, 32'h0000_0099, 1'b0, 1'b1);
    applyStimulus(OR_I, 32'h0000_0099, 32'h0, 5'd21, 1'b1);

    $display("[TB] reset during request");
    applyStimulus(LW_I, 32'h0000_0D00, 32'h0, 5'd22, 1'b1);
    checkOutput("rst_mid_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_req_after", 32'(dmem_req), 32'd0);
    checkOutput("rst_mid_ready", 32'(agex_ready), 32'd1);
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
